// File: rtl/pf_pkg.sv
// Shared types and constants for the ingress frame path: AXIS word/handshake
// structs, scanner status flags and the filter-buffer write FSM encoding.
package pf_pkg;

  typedef struct packed {
    logic        tvalid;
    logic [15:0] tdata;
    logic        tlast;
  } axis_source_t;

  typedef struct packed {
    logic tready;
  } axis_sink_t;

  typedef struct packed {
    logic scan_frame;
    logic scan_dst_mac;
    logic scan_src_mac;
    logic scan_type;
    logic scan_payload;
  } frame_status;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_DST     = 2'd1,
    W_BODY    = 2'd2,
    W_DISCARD = 2'd3
  } wr_state_t;

  localparam logic [15:0] BROADCAST_WORD = 16'hFFFF;
  localparam int          DST_MAC_WORDS  = 3;
  localparam int          FRAME_WORD_W   = 17;

  // Station MAC is carried most-significant word first on the wire.
  function automatic logic [15:0] mac_word(input logic [47:0] mac, input logic [1:0] idx);
    case (idx)
      2'd0:    mac_word = mac[47:32];
      2'd1:    mac_word = mac[31:16];
      2'd2:    mac_word = mac[15:0];
      default: mac_word = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: one write port, one synchronous read port
// with a single cycle of latency; read data holds while i_re is low.
module frame_ram #(
  parameter int ADDR_W       = 10,
  parameter int FRAME_WORD_W = 17
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [ADDR_W-1:0]       i_waddr,
  input  logic [FRAME_WORD_W-1:0] i_wdata,
  input  logic                    i_re,
  input  logic [ADDR_W-1:0]       i_raddr,
  output logic [FRAME_WORD_W-1:0] o_rdata
);

  logic [FRAME_WORD_W-1:0] r_mem [2**ADDR_W];
  logic [FRAME_WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ingress_filter_buffer.sv
// Destination-MAC filter and commit/rollback frame buffer behind the ingress FSM.
// Define INGRESS_FILTER_STATS_EN to add saturating accept/drop/truncate counters.
module ingress_filter_buffer
  import pf_pkg::*;
#(
  parameter int ADDR_W             = 10,
  parameter int ALMOST_FULL_MARGIN = 760
) (
  input  logic         clk,
  input  logic         reset,
  input  axis_source_t ingress_pkt,
  input  frame_status  status,
  input  logic         incomplete_frame,
  input  logic [47:0]  cfg_mac,
  input  logic         cfg_promisc,
  output logic         drop_current,
  output logic         almost_full,
`ifdef INGRESS_FILTER_STATS_EN
  output logic [31:0]  stat_accepted,
  output logic [31:0]  stat_mac_dropped,
  output logic [31:0]  stat_overflow_dropped,
  output logic [31:0]  stat_truncated,
`endif
  output axis_source_t egress_source,
  input  axis_sink_t   egress_sink
);

  localparam int               PTR_W    = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH    = PTR_W'(1) << ADDR_W;
  localparam logic [PTR_W-1:0] MARGIN   = PTR_W'(ALMOST_FULL_MARGIN);
  localparam logic [1:0]       LAST_IDX = 2'(DST_MAC_WORDS - 1);

  wr_state_t               r_state;
  logic [PTR_W-1:0]        r_wr_ptr, r_commit_ptr, r_rd_ptr;
  logic [1:0]              r_mac_idx;
  logic                    r_drop_current, r_almost_full, r_rd_valid;
  axis_source_t            r_egress;

  logic                    w_dst_word, w_body_word, w_write_due, w_full, w_mac_ok;
  logic                    w_drop_mac, w_drop_full, w_drop, w_we, w_commit, w_runt;
  logic                    w_load, w_fetch;
  logic [PTR_W-1:0]        w_used, w_free;
  logic [FRAME_WORD_W-1:0] w_rdata;
  logic                    w_unused;

  // The word that moves W_IDLE to W_DST is itself the first DST word.
  assign w_dst_word  = ingress_pkt.tvalid &&
                       ((r_state == W_IDLE && status.scan_dst_mac) || r_state == W_DST);
  assign w_body_word = ingress_pkt.tvalid && (r_state == W_BODY);
  assign w_write_due = (w_dst_word || w_body_word) && status.scan_frame && !incomplete_frame;
  assign w_used      = r_wr_ptr - r_rd_ptr;
  assign w_free      = DEPTH - w_used;
  assign w_full      = (w_used == DEPTH);
  assign w_mac_ok    = cfg_promisc || (ingress_pkt.tdata == BROADCAST_WORD) ||
                       (ingress_pkt.tdata == mac_word(cfg_mac, r_mac_idx));
  assign w_drop_mac  = w_write_due && w_dst_word && !w_mac_ok;
  assign w_drop_full = w_write_due && !w_drop_mac && w_full;
  assign w_drop      = w_drop_mac || w_drop_full;
  assign w_we        = w_write_due && !w_drop;
  assign w_commit    = w_we && w_body_word && ingress_pkt.tlast;
  // A frame ending inside its DST field can never be accepted.
  assign w_runt      = w_we && w_dst_word && ingress_pkt.tlast;
  assign w_unused    = ^{status.scan_src_mac, status.scan_type, status.scan_payload};

  // Write FSM, write/commit pointers, MAC word index and FSM-facing flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= W_IDLE;
      r_wr_ptr       <= '0;
      r_commit_ptr   <= '0;
      r_mac_idx      <= 2'd0;
      r_drop_current <= 1'b0;
      r_almost_full  <= 1'b0;
    end else begin
      r_drop_current <= w_drop;
      r_almost_full  <= (w_free < MARGIN);
      if (incomplete_frame) begin
        r_wr_ptr  <= r_commit_ptr;
        r_state   <= W_IDLE;
        r_mac_idx <= 2'd0;
      end else if (w_drop) begin
        r_wr_ptr  <= r_commit_ptr;
        r_state   <= W_DISCARD;
        r_mac_idx <= 2'd0;
      end else if (w_runt) begin
        r_wr_ptr  <= r_commit_ptr;
        r_state   <= W_IDLE;
        r_mac_idx <= 2'd0;
      end else if (w_we && w_dst_word) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (r_mac_idx == LAST_IDX) begin
          r_state   <= W_BODY;
          r_mac_idx <= 2'd0;
        end else begin
          r_state   <= W_DST;
          r_mac_idx <= r_mac_idx + 2'd1;
        end
      end else if (w_we) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_commit) begin
          r_commit_ptr <= r_wr_ptr + PTR_W'(1);
          r_state      <= W_IDLE;
        end
      end else if (r_state == W_DISCARD &&
                   ((ingress_pkt.tvalid && ingress_pkt.tlast) || !status.scan_frame)) begin
        r_state <= W_IDLE;
      end
    end
  end

  frame_ram #(
    .ADDR_W      (ADDR_W),
    .FRAME_WORD_W(FRAME_WORD_W)
  ) u_frame_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(r_wr_ptr[ADDR_W-1:0]),
    .i_wdata({ingress_pkt.tlast, ingress_pkt.tdata}),
    .i_re   (w_fetch),
    .i_raddr(r_rd_ptr[ADDR_W-1:0]),
    .o_rdata(w_rdata)
  );

  // RAM read register and egress register form a two-stage pipe; both advance together.
  assign w_load  = r_rd_valid && (!r_egress.tvalid || egress_sink.tready);
  assign w_fetch = (r_rd_ptr != r_commit_ptr) && (!r_rd_valid || w_load);

  // Read pointer, fetched-word flag and the egress output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_rd_valid <= 1'b0;
      r_egress   <= '0;
    end else begin
      if (w_fetch) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_rd_valid <= w_fetch || (r_rd_valid && !w_load);
      if (w_load) begin
        r_egress <= '{tvalid: 1'b1, tdata: w_rdata[15:0], tlast: w_rdata[FRAME_WORD_W-1]};
      end else if (egress_sink.tready) begin
        r_egress.tvalid <= 1'b0;
      end
    end
  end

  assign drop_current  = r_drop_current;
  assign almost_full   = r_almost_full;
  assign egress_source = r_egress;

`ifdef INGRESS_FILTER_STATS_EN
  logic        w_trunc;
  logic [31:0] r_stat_acc, r_stat_mac, r_stat_ovf, r_stat_trunc;

  assign w_trunc = incomplete_frame && (r_state == W_DST || r_state == W_BODY);

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    sat_inc = (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  // Saturating frame outcome counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_acc   <= 32'd0;
      r_stat_mac   <= 32'd0;
      r_stat_ovf   <= 32'd0;
      r_stat_trunc <= 32'd0;
    end else begin
      r_stat_acc   <= sat_inc(r_stat_acc, w_commit);
      r_stat_mac   <= sat_inc(r_stat_mac, w_drop_mac);
      r_stat_ovf   <= sat_inc(r_stat_ovf, w_drop_full);
      r_stat_trunc <= sat_inc(r_stat_trunc, w_trunc);
    end
  end

  assign stat_accepted         = r_stat_acc;
  assign stat_mac_dropped      = r_stat_mac;
  assign stat_overflow_dropped = r_stat_ovf;
  assign stat_truncated        = r_stat_trunc;
`endif

endmodule

// File: doc/ingress_filter_buffer.md
Name: ingress_filter_buffer

Overview:
Sits directly downstream of the ingress input FSM and consumes its registered word stream, frame status and incomplete-frame flag. Filters frames on destination MAC and writes accepted frame words into a circular frame buffer with commit/rollback. Drives the FSM's drop_current and almost_full inputs. Presents only fully committed frames on an egress AXIS interface.

Parameters:
ADDR_W, 10, buffer depth is 2**ADDR_W 17-bit words ({tlast, tdata})
ALMOST_FULL_MARGIN, 760, free words below which almost_full asserts (max frame 759 words + 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ingress_pkt  in  axis_source_t  registered word from the input FSM (tvalid, tdata[15:0], tlast)
status  in  frame_status  scan_frame/scan_dst_mac/scan_src_mac/scan_type/scan_payload
incomplete_frame  in  1  input FSM in FLUSH; current frame truncated
cfg_mac  in  48  station MAC; word0 = [47:32], word1 = [31:16], word2 = [15:0]
cfg_promisc  in  1  accept all destination MACs
drop_current  out  1  drop request to the input FSM
almost_full  out  1  backpressure request to the input FSM
egress_source  out  axis_source_t  committed frame words
egress_sink  in  axis_sink_t  downstream tready

Behaviour:
- Reset (clk/reset as decided: synchronous, active-high) clears all of the following to 0: wr_ptr, commit_ptr, rd_ptr (all ADDR_W+1 bits), drop_current, almost_full, egress_source.{tvalid,tdata,tlast}, mac_idx. Write FSM goes to W_IDLE. Buffer contents are undefined after reset.
- Reset mid-frame discards every uncommitted and unread word.
- Write FSM states: W_IDLE, W_DST, W_BODY, W_DISCARD.
  - W_IDLE -> W_DST on the first word with ingress_pkt.tvalid && status.scan_dst_mac.
  - W_DST -> W_BODY after the 3rd DST word if the MAC matches.
  - W_BODY -> W_IDLE when a word with tlast is written (commit).
  - Any state -> W_DISCARD on a drop cause.
  - W_DISCARD -> W_IDLE on ingress_pkt.tvalid && tlast, or when status.scan_frame is low.
- Write: in W_DST/W_BODY, write {tlast, tdata} at wr_ptr[ADDR_W-1:0] when ingress_pkt.tvalid && status.scan_frame, then increment wr_ptr.
- MAC match: mac_idx 0..2 counts DST words. A word matches if it equals the corresponding cfg_mac word or 16'hFFFF (broadcast). A frame passes if all 3 words match, or if cfg_promisc is set.
- Drop causes:
  - DST mismatch.
  - Buffer full, i.e. (wr_ptr - rd_ptr) == 2**ADDR_W when a write is due; the word is not written.
- On a drop cause:
  - wr_ptr <= commit_ptr (rollback).
  - drop_current is a registered single-cycle pulse asserted the cycle after the cause.
- incomplete_frame high: wr_ptr <= commit_ptr and state goes to W_IDLE. drop_current is not asserted because the FSM is already returning to IDLE.
- Commit: a tlast word written in W_BODY sets commit_ptr <= wr_ptr + 1 in the same edge.
- Simultaneous events:
  - tlast together with a drop cause: drop wins, no commit.
  - Commit together with a read: both proceed.
- almost_full is registered: free = 2**ADDR_W - (wr_ptr - rd_ptr) (modular, ADDR_W+1 bits); almost_full = free < ALMOST_FULL_MARGIN. It uses wr_ptr, not commit_ptr, so in-flight words count.
- Read side:
  - Synchronous-read RAM feeding a 1-entry output register.
  - egress_source.tvalid is high when the output register holds a word.
  - A word is consumed on tvalid && tready; rd_ptr advances when a word is fetched.
  - Prefetch occurs when rd_ptr != commit_ptr and the output register is empty or being consumed.
  - First word of a frame appears on egress 2 cycles after its commit. Sustained throughput is 1 word/cycle.
  - egress_source holds stable while tvalid && !tready.
- Pointer wrap: pointers wrap modulo 2**(ADDR_W+1). The MSB distinguishes full from empty.

Optional Feature:
Macro: INGRESS_FILTER_STATS_EN.
- Defined: adds outputs stat_accepted, stat_mac_dropped, stat_overflow_dropped, stat_truncated (32 bits each, saturating, reset to 0). Each increments by 1 on commit, MAC drop, full drop and incomplete_frame rollback respectively.
- Undefined: no ports and no counters.

Decomposition:
- Shared package pf_pkg (alongside axis_source_t, axis_sink_t, frame_status) adds:
  - write-FSM state enum;
  - BROADCAST_WORD = 16'hFFFF;
  - DST_MAC_WORDS = 3;
  - FRAME_WORD_W = 17.
- Sub-module frame_ram: simple dual-port, one write port and one synchronous read port, 1-cycle latency, parameterised ADDR_W/FRAME_WORD_W.

Test Plan:
- cfg_mac=0x0011_2233_4455; frame with DST 0011/2233/4455, then 4 body words, last with tlast; egress_sink.tready=1 -> 7 words out in order, tlast on the 7th; drop_current never high.
- Same frame with DST word1=0x2234 -> drop_current pulses 1 cycle after word1; wr_ptr returns to commit_ptr; no egress output.
- DST FFFF/FFFF/FFFF and cfg_promisc=0 -> frame accepted; DST mismatch with cfg_promisc=1 -> frame accepted.
- incomplete_frame asserted after 5 written words -> wr_ptr rolls back; the next good frame egresses intact.
- ADDR_W=6, ALMOST_FULL_MARGIN=20, tready=0; write 45-word frame -> almost_full rises when free < 20. A 70-word frame hits full -> drop_current pulses and the 45-word frame stays intact.
- tready toggling 1/0 per cycle across pointer wrap -> no lost or duplicated words; egress data holds while stalled.
